pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage MIPS32 pipeline. It drives the load-enable and flush (bubble-insert) controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB buffers. It resolves load-use hazards, branch-taken redirects signalled from the EX/MEM buffer (Branch & ZF), and multi-cycle data-memory accesses via a req/ready handshake. Because the pipeline buffers have no reset, it also sequences a post-reset flush.

## Interface
Parameters:
- INIT_CYCLES, 3: cycles of full-pipeline flush after reset release.
- MAX_WAIT, 255: maximum MEM_WAIT cycles before error.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in IF/ID.
- ex_rt  in  5  destination of the instruction in ID/EX.
- ex_mem_read  in  1  ID/EX MemToRead.
- mem_branch, mem_zf  in  1 each  EX/MEM Branch and ZF.
- mem_read, mem_write  in  1 each  EX/MEM MemToRead/MemToWrite.
- dmem_ready  in  1  data memory has completed the current access.
- dmem_req  out  1  data-memory access request.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  buffer load enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (all controls 0).
- pc_sel_branch  out  1  selects the branch target into the PC.
- err  out  1  memory timeout, sticky.
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters.

## Operation
- FSM states: INIT, RUN, MEM_WAIT, ERROR.
- INIT:
  - All four flushes = 1; pc_en = 0; all buffer enables = 1.
  - Down-counter loads INIT_CYCLES on reset.
  - Go to RUN when the counter reaches 0 (exactly INIT_CYCLES cycles in INIT).
- RUN, defaults: all enables = 1; flushes, pc_sel_branch and dmem_req = 0.
- Memory access, mem_read | mem_write:
  - dmem_req = 1.
  - If dmem_ready is high in the same cycle, the pipeline advances normally.
  - Otherwise all enables = 0, memwb_flush = 1 (bubble into WB), and the next state is MEM_WAIT.
- Branch taken, mem_branch & mem_zf, with the pipeline advancing:
  - pc_sel_branch = 1.
  - ifid_flush = idex_flush = exmem_flush = 1.
  - flush_cnt increments.
- Load-use hazard: ex_mem_read & ex_rt != 0 & (ex_rt == id_rs | ex_rt == id_rt).
  - pc_en = 0, ifid_en = 0, idex_flush = 1.
- Priority, highest first:
  1. Memory stall.
  2. Branch taken. It overrides load-use; the younger instructions die.
  3. Load-use.
- MEM_WAIT:
  - dmem_req = 1; all enables = 0; memwb_flush = 1.
  - A wait counter increments each cycle.
  - On dmem_ready, return to RUN. That cycle behaves as a RUN cycle with the access completing: enables = 1, and branch/load-use rules apply.
  - If the wait counter reaches MAX_WAIT without ready, go to ERROR.
- ERROR: all enables = 0, dmem_req = 0, err = 1. Held until rst_n.
- stall_cnt increments in every cycle in which pc_en = 0 outside INIT and ERROR. Both counters saturate at all-ones.
- mem_read and mem_write both high: treated as a single access.
- Branch and memory access together cannot occur legally. If they do, the memory access is served first and the branch is applied on the completing cycle.

## Timing
- Enables, flushes, pc_sel_branch and dmem_req are combinational from the state plus the current inputs. They act on the next clock edge.
- Reset values (rst_n low):
  - State = INIT; counters = 0; err = 0.
  - Outputs follow INIT: flushes = 1, pc_en = 0, other enables = 1.
- Load-use costs 1 bubble cycle. A taken branch costs 3 squashed instructions. A memory access taking N cycles to ready costs N-1 stall cycles.
- The wait counter clears on each entry to MEM_WAIT.
- Reset asserted mid-MEM_WAIT: immediate return to INIT; dmem_req drops asynchronously.

## Structure
- Package pipeline_ctrl_pkg holds:
  - The state enum (INIT, RUN, MEM_WAIT, ERROR).
  - Default parameter constants.
  - The REG_ZERO = 5'd0 constant.
- One sub-module, sat_counter (width-parameterised, inc, saturating, async active-low reset), instantiated twice.
- The FSM, the wait/init counters and the combinational hazard logic live in the top module.

## Test plan
- Reset release, INIT_CYCLES = 3 → flushes high and pc_en low for exactly 3 cycles, then RUN with all enables 1.
- ex_mem_read = 1, ex_rt = 8, id_rs = 8 → one cycle with pc_en = 0, ifid_en = 0, idex_flush = 1; stall_cnt = 1. Repeat with ex_rt = 0 → no stall.
- mem_read = 1, dmem_ready rising after 4 cycles → 3 stall cycles in MEM_WAIT, dmem_req held high throughout, stall_cnt = 3, resume on the 4th cycle.
- mem_branch = mem_zf = 1 concurrent with a load-use match → pc_sel_branch = 1, three flushes, no load-use stall, flush_cnt = 1.
- MAX_WAIT = 4, dmem_ready held low → ERROR after 4 wait cycles, err = 1, all enables 0; rst_n pulse clears err and returns to INIT.
- CNT_W = 4 with 20 load-use stalls → stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      INIT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      ERROR    = 2'd3
   } state_t;

   localparam int DEF_INIT_CYCLES = 3;
   localparam int DEF_MAX_WAIT    = 255;
   localparam int DEF_CNT_W       = 16;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Width needed to hold 0..max_val, never less than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_r;

   // Count enabled events, holding at the maximum value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {W{1'b0}};
      end else if (inc && (count_r != {W{1'b1}})) begin
         count_r <= count_r + W'(1'b1);
      end
   end

   assign count = count_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: post-reset flush,
// load-use bubbles, taken-branch squash and data-memory wait handling.
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int INIT_CYCLES = DEF_INIT_CYCLES,
   parameter int MAX_WAIT    = DEF_MAX_WAIT,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       ex_rt,
   input  logic             ex_mem_read,
   input  logic             mem_branch,
   input  logic             mem_zf,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             pc_sel_branch,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int INIT_W = cnt_width(INIT_CYCLES);
   localparam int WAIT_W = cnt_width(MAX_WAIT);

   state_t              state_r;
   state_t              state_s;
   logic [INIT_W-1:0]   init_cnt_r;
   logic [WAIT_W-1:0]   wait_cnt_r;
   logic [WAIT_W-1:0]   wait_inc_s;
   logic                err_r;
   logic                mem_acc_s;
   logic                branch_s;
   logic                load_use_s;
   logic                advance_s;
   logic                stall_inc_s;

   assign mem_acc_s  = mem_read | mem_write;
   assign branch_s   = mem_branch & mem_zf;
   assign load_use_s = ex_mem_read && (ex_rt != REG_ZERO) &&
                       ((ex_rt == id_rs) || (ex_rt == id_rt));
   // In MEM_WAIT the access is already outstanding, so only ready matters.
   assign advance_s  = (state_r == MEM_WAIT) ? dmem_ready : (!mem_acc_s || dmem_ready);
   assign wait_inc_s = wait_cnt_r + WAIT_W'(1'b1);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= INIT;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state selection.
   always_comb begin
      state_s = state_r;
      case (state_r)
         INIT: begin
            if (init_cnt_r <= INIT_W'(1'b1)) state_s = RUN;
            else                             state_s = INIT;
         end
         RUN: begin
            if (mem_acc_s && !dmem_ready) state_s = MEM_WAIT;
            else                          state_s = RUN;
         end
         MEM_WAIT: begin
            if (dmem_ready)                           state_s = RUN;
            else if (wait_inc_s == WAIT_W'(MAX_WAIT)) state_s = ERROR;
            else                                      state_s = MEM_WAIT;
         end
         ERROR:   state_s = ERROR;
         default: state_s = INIT;
      endcase
   end

   // Init down-counter, per-wait counter and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_cnt_r <= INIT_W'(INIT_CYCLES);
         wait_cnt_r <= {WAIT_W{1'b0}};
         err_r      <= 1'b0;
      end else begin
         if ((state_r == INIT) && (init_cnt_r != {INIT_W{1'b0}})) begin
            init_cnt_r <= init_cnt_r - INIT_W'(1'b1);
         end
         if (state_r == MEM_WAIT) wait_cnt_r <= wait_inc_s;
         else                     wait_cnt_r <= {WAIT_W{1'b0}};
         if (state_s == ERROR) err_r <= 1'b1;
      end
   end

   // Enables, flushes and request from state plus current hazards.
   always_comb begin
      dmem_req      = 1'b0;
      pc_en         = 1'b1;
      ifid_en       = 1'b1;
      idex_en       = 1'b1;
      exmem_en      = 1'b1;
      memwb_en      = 1'b1;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      exmem_flush   = 1'b0;
      memwb_flush   = 1'b0;
      pc_sel_branch = 1'b0;
      case (state_r)
         INIT: begin
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
         end
         RUN, MEM_WAIT: begin
            dmem_req = (state_r == MEM_WAIT) || mem_acc_s;
            if (!advance_s) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               exmem_en    = 1'b0;
               memwb_en    = 1'b0;
               memwb_flush = 1'b1;
            end else if (branch_s) begin
               pc_sel_branch = 1'b1;
               ifid_flush    = 1'b1;
               idex_flush    = 1'b1;
               exmem_flush   = 1'b1;
            end else if (load_use_s) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
            end else begin
               pc_sel_branch = 1'b0;
            end
         end
         default: begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
         end
      endcase
   end

   assign stall_inc_s = !pc_en && ((state_r == RUN) || (state_r == MEM_WAIT));
   assign err         = err_r;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc_s),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pc_sel_branch),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven, scoreboard-checked bench for pipeline_hazard_ctrl
// (INIT_CYCLES=3, MAX_WAIT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;

   typedef struct packed {
      logic       dmem_req;
      logic       pc_en;
      logic       ifid_en;
      logic       idex_en;
      logic       exmem_en;
      logic       memwb_en;
      logic       ifid_flush;
      logic       idex_flush;
      logic       exmem_flush;
      logic       memwb_flush;
      logic       pc_sel_branch;
      logic       err;
      logic [3:0] stall_cnt;
      logic [3:0] flush_cnt;
   } outs_t;

   typedef struct packed {
      logic [4:0] id_rs;
      logic [4:0] id_rt;
      logic [4:0] ex_rt;
      logic       ex_mem_read;
      logic       mem_branch;
      logic       mem_zf;
      logic       mem_read;
      logic       mem_write;
      logic       dmem_ready;
   } ins_t;

   typedef struct {
      ins_t  in;
      outs_t exp;
      outs_t mask;
   } vec_t;

   typedef struct {
      outs_t exp;
      outs_t mask;
      int    id;
   } sb_t;

   logic       clk;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       ex_mem_read, mem_branch, mem_zf, mem_read, mem_write, dmem_ready;
   logic       dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_sel_branch, err;
   logic [3:0] stall_cnt, flush_cnt;

   int  checks   = 0;
   int  failures = 0;
   sb_t sb_q[$];
   vec_t tbl[14];
   outs_t m_all, m_err;

   pipeline_hazard_ctrl #(.INIT_CYCLES(3), .MAX_WAIT(4), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
      .ex_mem_read(ex_mem_read), .mem_branch(mem_branch), .mem_zf(mem_zf),
      .mem_read(mem_read), .mem_write(mem_write), .dmem_ready(dmem_ready),
      .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
      .pc_sel_branch(pc_sel_branch), .err(err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic ins_t mk(input int rs, input int rt, input int ert, input logic emr,
                               input logic br, input logic zf, input logic mr,
                               input logic mw, input logic rdy);
      ins_t i;
      i.id_rs = 5'(rs); i.id_rt = 5'(rt); i.ex_rt = 5'(ert);
      i.ex_mem_read = emr; i.mem_branch = br; i.mem_zf = zf;
      i.mem_read = mr; i.mem_write = mw; i.dmem_ready = rdy;
      return i;
   endfunction

   function automatic outs_t o_run(input int s, input int f);
      outs_t o;
      o = '0;
      o.pc_en = 1'b1; o.ifid_en = 1'b1; o.idex_en = 1'b1; o.exmem_en = 1'b1; o.memwb_en = 1'b1;
      o.stall_cnt = 4'(s); o.flush_cnt = 4'(f);
      return o;
   endfunction

   function automatic outs_t o_init(input int s, input int f);
      outs_t o;
      o = o_run(s, f);
      o.pc_en = 1'b0;
      o.ifid_flush = 1'b1; o.idex_flush = 1'b1; o.exmem_flush = 1'b1; o.memwb_flush = 1'b1;
      return o;
   endfunction

   function automatic outs_t o_lu(input int s, input int f);
      outs_t o;
      o = o_run(s, f);
      o.pc_en = 1'b0; o.ifid_en = 1'b0; o.idex_flush = 1'b1;
      return o;
   endfunction

   function automatic outs_t o_br(input int s, input int f, input logic req);
      outs_t o;
      o = o_run(s, f);
      o.pc_sel_branch = 1'b1; o.dmem_req = req;
      o.ifid_flush = 1'b1; o.idex_flush = 1'b1; o.exmem_flush = 1'b1;
      return o;
   endfunction

   function automatic outs_t o_memok(input int s, input int f);
      outs_t o;
      o = o_run(s, f);
      o.dmem_req = 1'b1;
      return o;
   endfunction

   function automatic outs_t o_mst(input int s, input int f);
      outs_t o;
      o = '0;
      o.dmem_req = 1'b1; o.memwb_flush = 1'b1;
      o.stall_cnt = 4'(s); o.flush_cnt = 4'(f);
      return o;
   endfunction

   function automatic outs_t o_err(input int s, input int f);
      outs_t o;
      o = '0;
      o.err = 1'b1;
      o.stall_cnt = 4'(s); o.flush_cnt = 4'(f);
      return o;
   endfunction

   function automatic outs_t actual();
      outs_t a;
      a.dmem_req = dmem_req; a.pc_en = pc_en; a.ifid_en = ifid_en; a.idex_en = idex_en;
      a.exmem_en = exmem_en; a.memwb_en = memwb_en; a.ifid_flush = ifid_flush;
      a.idex_flush = idex_flush; a.exmem_flush = exmem_flush; a.memwb_flush = memwb_flush;
      a.pc_sel_branch = pc_sel_branch; a.err = err;
      a.stall_cnt = stall_cnt; a.flush_cnt = flush_cnt;
      return a;
   endfunction

   task automatic drive(input ins_t i);
      id_rs = i.id_rs; id_rt = i.id_rt; ex_rt = i.ex_rt;
      ex_mem_read = i.ex_mem_read; mem_branch = i.mem_branch; mem_zf = i.mem_zf;
      mem_read = i.mem_read; mem_write = i.mem_write; dmem_ready = i.dmem_ready;
   endtask

   task automatic push(input outs_t e, input outs_t m, input int id);
      sb_t x;
      x.exp = e; x.mask = m; x.id = id;
      sb_q.push_back(x);
   endtask

   task automatic pop_check();
      sb_t   x;
      outs_t a;
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty got=none exp=entry");
      end else begin
         x = sb_q.pop_front();
         a = actual();
         if (((a ^ x.exp) & x.mask) != '0) begin
            failures++;
            $display("FAIL vec%0d got=%h exp=%h mask=%h", x.id, a, x.exp, x.mask);
         end
      end
   endtask

   // One cycle: drive at posedge+1, compare at negedge, end at next posedge+1.
   task automatic step(input ins_t i, input outs_t e, input outs_t m, input int id);
      drive(i);
      push(e, m, id);
      @(negedge clk);
      pop_check();
      @(posedge clk);
      #1;
   endtask

   initial begin
      ins_t idle, lu, mrd, mrd_r, bm, bm_r;
      idle  = mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      lu    = mk(8, 0, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      mrd   = mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      mrd_r = mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      bm    = mk(0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      bm_r  = mk(0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      m_all = '1;
      m_err = '1;
      m_err.ifid_flush = 1'b0; m_err.idex_flush = 1'b0; m_err.exmem_flush = 1'b0;
      m_err.memwb_flush = 1'b0; m_err.pc_sel_branch = 1'b0;

      tbl[0]  = '{idle, o_init(0, 0), m_all};
      tbl[1]  = '{idle, o_init(0, 0), m_all};
      tbl[2]  = '{idle, o_init(0, 0), m_all};
      tbl[3]  = '{idle, o_run(0, 0), m_all};
      tbl[4]  = '{lu, o_lu(0, 0), m_all};
      tbl[5]  = '{idle, o_run(1, 0), m_all};
      tbl[6]  = '{mk(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), o_run(1, 0), m_all};
      tbl[7]  = '{mk(3, 5, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), o_lu(1, 0), m_all};
      tbl[8]  = '{mk(5, 0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), o_run(2, 0), m_all};
      tbl[9]  = '{mk(8, 0, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), o_br(2, 0, 1'b0), m_all};
      tbl[10] = '{mk(0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), o_run(2, 1), m_all};
      tbl[11] = '{mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), o_memok(2, 1), m_all};
      tbl[12] = '{mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1), o_memok(2, 1), m_all};
      tbl[13] = '{idle, o_run(2, 1), m_all};

      rst_n = 1'b0;
      drive(idle);
      repeat (2) @(posedge clk);
      #1;
      step(idle, o_init(0, 0), m_all, 100);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) step(tbl[i].in, tbl[i].exp, tbl[i].mask, i);

      // Access ready on its 4th cycle: three stall cycles, then completion.
      step(mrd,   o_mst(2, 1),   m_all, 200);
      step(mrd,   o_mst(3, 1),   m_all, 201);
      step(mrd,   o_mst(4, 1),   m_all, 202);
      step(mrd_r, o_memok(5, 1), m_all, 203);
      step(idle,  o_run(5, 1),   m_all, 204);

      // Illegal branch+access: access first, branch on the completing cycle.
      step(bm,   o_mst(5, 1),        m_all, 210);
      step(bm_r, o_br(6, 1, 1'b1),   m_all, 211);
      step(idle, o_run(6, 2),        m_all, 212);

      // Timeout: one RUN stall plus four wait cycles, then sticky ERROR.
      for (int k = 0; k < 5; k++) step(mrd, o_mst(6 + k, 2), m_all, 220 + k);
      step(idle, o_err(11, 2), m_err, 225);
      step(lu,   o_err(11, 2), m_err, 226);

      rst_n = 1'b0;
      step(idle, o_init(0, 0), m_all, 230);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) step(idle, o_init(0, 0), m_all, 231 + k);
      step(idle, o_run(0, 0), m_all, 234);

      for (int k = 0; k < 20; k++) step(lu, o_lu((k > 15) ? 15 : k, 0), m_all, 240 + k);
      step(idle, o_run(15, 0), m_all, 260);

      // Reset in the middle of MEM_WAIT drops the request immediately.
      step(mrd, o_mst(15, 0), m_all, 270);
      drive(mrd);
      #1;
      push(o_mst(15, 0), m_all, 271);
      pop_check();
      rst_n = 1'b0;
      #1;
      push(o_init(0, 0), m_all, 272);
      pop_check();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
